// File: rtl/itcm_arb_if.sv
// Bus bundle for the ITCM arbiter: IFU and LSU request/response channels plus the SRAM port.
// The master side is the environment (requesters and SRAM); the slave side is the arbiter.
interface itcm_arb_if #(
    parameter int AW = 16
);
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [31:0]     ifu_req_addr;
    logic            ifu_rsp_valid;
    logic            ifu_rsp_ready;
    logic            ifu_rsp_err;
    logic [31:0]     ifu_rsp_rdata;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [31:0]     lsu_req_addr;
    logic            lsu_req_read;
    logic [31:0]     lsu_req_wdata;
    logic [3:0]      lsu_req_wmask;
    logic            lsu_rsp_valid;
    logic            lsu_rsp_ready;
    logic            lsu_rsp_err;
    logic [31:0]     lsu_rsp_rdata;

    logic            ram_cs;
    logic            ram_we;
    logic [3:0]      ram_wem;
    logic [AW-3:0]   ram_addr;
    logic [31:0]     ram_din;
    logic [31:0]     ram_dout;

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        output lsu_req_valid, lsu_req_addr, lsu_req_read, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
        output ram_dout,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata,
        input  ram_cs, ram_we, ram_wem, ram_addr, ram_din
    );

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        input  lsu_req_valid, lsu_req_addr, lsu_req_read, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
        input  ram_dout,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata,
        output ram_cs, ram_we, ram_wem, ram_addr, ram_din
    );
endinterface

// File: rtl/itcm_arb.sv
// Single-port ITCM arbiter: LSU-priority with IFU starvation relief, 1-cycle SRAM latency,
// in-order responses through a 2-entry FIFO with a bypass path from the data phase.
module itcm_arb #(
    parameter int          AW           = 16,
    parameter logic [31:0] ITCM_BASE    = 32'h8000_0000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    itcm_arb_if.slave  bus
);
    localparam int SCW   = $clog2(STARVE_LIMIT + 1);
    localparam int DEPTH = 2;

    typedef struct packed {
        logic        src;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [1:0]     rsp_cnt_r;
    logic           dphase_r;
    logic           src_r;
    logic           err_r;
    logic           is_read_r;
    logic [SCW-1:0] starve_cnt_r;
    rsp_t           fifo_r    [DEPTH];
    rsp_t           fifo_next [DEPTH];

    logic        credit_ok;
    logic        starve;
    logic        ifu_hsk;
    logic        lsu_hsk;
    logic        hsk;
    logic        addr_err;
    logic        is_read;
    logic [31:0] dp_data;
    rsp_t        dp_rsp;
    rsp_t        head;
    logic        head_valid;
    logic        pop;
    logic        fifo_pop;
    logic        push_en;
    logic        wr_idx;
    logic        unused_addr_lsbs;

    // Credit counts everything already accepted but not yet consumed, so no ready
    // ever looks at a response-side ready.
    assign credit_ok = (3'(rsp_cnt_r) + 3'(dphase_r)) <= 3'd1;
    assign starve    = (starve_cnt_r == SCW'(STARVE_LIMIT));

    assign bus.lsu_req_ready = credit_ok & ~(bus.ifu_req_valid & starve);
    assign bus.ifu_req_ready = credit_ok & ~(bus.lsu_req_valid & ~starve);

    assign lsu_hsk = bus.lsu_req_valid & bus.lsu_req_ready;
    assign ifu_hsk = bus.ifu_req_valid & bus.ifu_req_ready;
    assign hsk     = (lsu_hsk | ifu_hsk) & ~rst;

    assign addr_err = lsu_hsk ? (bus.lsu_req_addr[31:AW] != ITCM_BASE[31:AW])
                              : (bus.ifu_req_addr[31:AW] != ITCM_BASE[31:AW]);
    assign is_read  = lsu_hsk ? bus.lsu_req_read : 1'b1;

    assign bus.ram_cs   = hsk & ~addr_err;
    assign bus.ram_we   = bus.ram_cs & ~is_read;
    assign bus.ram_wem  = bus.ram_we ? bus.lsu_req_wmask : 4'b0000;
    assign bus.ram_addr = lsu_hsk ? bus.lsu_req_addr[AW-1:2] : bus.ifu_req_addr[AW-1:2];
    assign bus.ram_din  = bus.lsu_req_wdata;

    assign unused_addr_lsbs = &{1'b0, bus.ifu_req_addr[1:0], bus.lsu_req_addr[1:0]};

    assign dp_data = (is_read_r & ~err_r) ? bus.ram_dout : 32'h0;
    assign dp_rsp  = {src_r, err_r, dp_data};

    // Oldest queued entry wins; an empty FIFO exposes the data-phase result directly.
    assign head_valid = (rsp_cnt_r != 2'd0) | dphase_r;
    assign head       = (rsp_cnt_r != 2'd0) ? fifo_r[0] : dp_rsp;

    assign bus.ifu_rsp_valid = head_valid & ~head.src & ~rst;
    assign bus.lsu_rsp_valid = head_valid &  head.src & ~rst;
    assign bus.ifu_rsp_err   = head.err;
    assign bus.lsu_rsp_err   = head.err;
    assign bus.ifu_rsp_rdata = head.data;
    assign bus.lsu_rsp_rdata = head.data;

    assign pop      = head_valid & ~rst & (head.src ? bus.lsu_rsp_ready : bus.ifu_rsp_ready);
    assign fifo_pop = pop & (rsp_cnt_r != 2'd0);
    assign push_en  = dphase_r & ~((rsp_cnt_r == 2'd0) & pop);
    assign wr_idx   = fifo_pop ? ~rsp_cnt_r[0] : rsp_cnt_r[0];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_next[i] = fifo_r[i];
        end
        if (fifo_pop) begin
            fifo_next[0] = fifo_r[1];
        end
        if (push_en) begin
            fifo_next[wr_idx] = dp_rsp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_cnt_r    <= 2'd0;
            dphase_r     <= 1'b0;
            starve_cnt_r <= '0;
        end else begin
            rsp_cnt_r <= rsp_cnt_r + 2'(push_en) - 2'(fifo_pop);
            dphase_r  <= hsk;
            if (!bus.ifu_req_valid || ifu_hsk) begin
                starve_cnt_r <= '0;
            end else if (lsu_hsk && !starve) begin
                starve_cnt_r <= starve_cnt_r + SCW'(1);
            end
        end
        src_r     <= lsu_hsk;
        err_r     <= addr_err;
        is_read_r <= is_read;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_r[i] <= fifo_next[i];
        end
    end
endmodule
